// File: rtl/regs_banked_ctx.sv
// Register bank for the accumulator MCU: opcode, immediate, PSR and a banked accumulator file.
// Define REGS_CTX_STACK_EN to build the {bank, psr, acc[bank]} interrupt context stack.
`ifndef MCU_LOAD
`define MCU_LOAD 8'h01
`endif

module regs_banked_ctx #(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int PSR_WIDTH  = 4,
    parameter int NUM_ACC    = 4,
    parameter int CTX_DEPTH  = 4,
    parameter logic [INST_WIDTH-1:0] OPCODE_RST = `MCU_LOAD,
    localparam int BW = $clog2(NUM_ACC),
    localparam int CW = $clog2(CTX_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic                  opcode_update,
    output logic [INST_WIDTH-1:0] opcode,
    input  logic                  imm_update,
    input  logic                  psr_update,
    input  logic [PSR_WIDTH-1:0]  apsr,
    output logic [PSR_WIDTH-1:0]  psr,
    input  logic                  bank_update,
    input  logic [BW-1:0]         bank_sel,
    output logic [BW-1:0]         bank,
    input  logic                  acc_update,
    input  logic [DATA_WIDTH-1:0] alu,
    output logic [DATA_WIDTH-1:0] opa,
    output logic [DATA_WIDTH-1:0] opb,
    input  logic [DATA_WIDTH-1:0] dmem_data_r,
    output logic [DATA_WIDTH-1:0] dmem_data_w,
    output logic [ADDR_WIDTH-1:0] dmem_addr_reg,
    input  logic                  ctx_push,
    input  logic                  ctx_pop,
    input  logic                  ctx_err_clr,
    output logic [CW-1:0]         ctx_count,
    output logic                  ctx_full,
    output logic                  ctx_empty,
    output logic                  ctx_err
);

    logic [INST_WIDTH-1:0] opcode_q;
    logic [INST_WIDTH-1:0] imm_q;
    logic [PSR_WIDTH-1:0]  psr_q;
    logic [BW-1:0]         bank_q;
    logic [DATA_WIDTH-1:0] acc_q [NUM_ACC];

    // restore path from the context stack (tied off when the stack is not built)
    logic                  do_pop;
    logic [BW-1:0]         pop_bank;
    logic [PSR_WIDTH-1:0]  pop_psr;
    logic [DATA_WIDTH-1:0] pop_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= OPCODE_RST;
            imm_q    <= '0;
        end else begin
            if (opcode_update) opcode_q <= imem_data;
            if (imm_update)    imm_q    <= imem_data;
        end
    end

    // a restore takes priority over same-edge bank/psr updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
            psr_q  <= '0;
        end else if (do_pop) begin
            bank_q <= pop_bank;
            psr_q  <= pop_psr;
        end else begin
            if (bank_update) bank_q <= bank_sel;
            if (psr_update)  psr_q  <= apsr;
        end
    end

    // acc_update always targets the pre-edge bank, even alongside bank_update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
        end else if (do_pop) begin
            acc_q[pop_bank] <= pop_acc;
        end else if (acc_update) begin
            acc_q[bank_q] <= alu;
        end
    end

    assign opcode        = opcode_q;
    assign psr           = psr_q;
    assign bank          = bank_q;
    assign opa           = acc_q[bank_q];
    assign opb           = DATA_WIDTH'(imm_q);
    assign dmem_data_w   = acc_q[bank_q];
    assign dmem_addr_reg = ADDR_WIDTH'(acc_q[bank_q]);

`ifdef REGS_CTX_STACK_EN
    localparam int PW    = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
    localparam int SLOTS = 1 << PW;

    logic [CW-1:0]         count_q;
    logic                  err_q;
    logic [BW-1:0]         stk_bank [SLOTS];
    logic [PSR_WIDTH-1:0]  stk_psr  [SLOTS];
    logic [DATA_WIDTH-1:0] stk_acc  [SLOTS];
    logic                  full;
    logic                  empty;
    logic                  do_push;
    logic                  err_set;
    logic [CW-1:0]         top;

    assign full    = (count_q == CW'(CTX_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = ctx_push & ~ctx_pop & ~full;
    assign do_pop  = ctx_pop & ~ctx_push & ~empty;
    assign err_set = (ctx_push & ctx_pop) | (ctx_push & full) | (ctx_pop & empty);
    assign top     = count_q - CW'(1);

    assign pop_bank = stk_bank[top[PW-1:0]];
    assign pop_psr  = stk_psr[top[PW-1:0]];
    assign pop_acc  = stk_acc[top[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (do_push)      count_q <= count_q + CW'(1);
            else if (do_pop)  count_q <= top;
            if (err_set)          err_q <= 1'b1;
            else if (ctx_err_clr) err_q <= 1'b0;
        end
    end

    // entries need no reset: the count alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            stk_bank[count_q[PW-1:0]] <= bank_q;
            stk_psr[count_q[PW-1:0]]  <= psr_q;
            stk_acc[count_q[PW-1:0]]  <= acc_q[bank_q];
        end
    end

    assign ctx_count = count_q;
    assign ctx_full  = full;
    assign ctx_empty = empty;
    assign ctx_err   = err_q;

    logic unused_sig;
    assign unused_sig = ^{dmem_data_r, top};
`else
    assign do_pop    = 1'b0;
    assign pop_bank  = '0;
    assign pop_psr   = '0;
    assign pop_acc   = '0;
    assign ctx_count = '0;
    assign ctx_full  = 1'b0;
    assign ctx_empty = 1'b1;
    assign ctx_err   = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{dmem_data_r, ctx_push, ctx_pop, ctx_err_clr};
`endif

endmodule

// File: doc/regs_banked_ctx.md
# regs_banked_ctx

Parametrised register bank for the accumulator MCU datapath. It holds the opcode, immediate and PSR registers and a file of `NUM_ACC` selectable accumulators. A hardware context stack saves and restores {bank, PSR, active accumulator} on interrupt entry and return. The bank sits between instruction/data memories, the ALU and the control FSM; the control FSM drives all `*_update`, `bank_update` and `ctx_*` strobes.

## Interface
- `DATA_WIDTH`, 8, accumulator/ALU/data-memory width
- `INST_WIDTH`, 8, instruction word width (opcode and immediate)
- `ADDR_WIDTH`, 8, data-memory address width
- `PSR_WIDTH`, 4, PSR width (= APSR width)
- `NUM_ACC`, 4, accumulator count; power of two, ≥2; `BW = clog2(NUM_ACC)`
- `CTX_DEPTH`, 4, context stack entries, ≥1; `CW = clog2(CTX_DEPTH+1)`
- `OPCODE_RST`, `` `MCU_LOAD ``, opcode reset value

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_data` in INST_WIDTH: instruction memory data.
- `opcode_update` in 1: load opcode from `imem_data`.
- `opcode` out INST_WIDTH: current instruction.
- `imm_update` in 1: load immediate from `imem_data`.
- `psr_update` in 1: load PSR from `apsr`.
- `apsr` in PSR_WIDTH: ALU flags.
- `psr` out PSR_WIDTH: program status register.
- `bank_update` in 1: load active bank from `bank_sel`.
- `bank_sel` in BW: new active accumulator index.
- `bank` out BW: active accumulator index.
- `acc_update` in 1: write `alu` into `acc[bank]`.
- `alu` in DATA_WIDTH: ALU result.
- `opa` out DATA_WIDTH: `acc[bank]`.
- `opb` out DATA_WIDTH: immediate, zero-extended or truncated to DATA_WIDTH.
- `dmem_data_r` in DATA_WIDTH: data memory read data. Unused; kept for port compatibility.
- `dmem_data_w` out DATA_WIDTH: `acc[bank]`.
- `dmem_addr_reg` out ADDR_WIDTH: `acc[bank]`, zero-extended or truncated to ADDR_WIDTH.
- `ctx_push` in 1: save context.
- `ctx_pop` in 1: restore context.
- `ctx_err_clr` in 1: clear `ctx_err`.
- `ctx_count` out CW: occupied stack entries.
- `ctx_full` out 1: `ctx_count == CTX_DEPTH`.
- `ctx_empty` out 1: `ctx_count == 0`.
- `ctx_err` out 1: sticky overflow/underflow/conflict flag.

## Operation
- Reset values:
  - `opcode` = OPCODE_RST.
  - `psr`, `bank`, all accumulators, immediate, `ctx_count`, `ctx_err` = 0.
  - `ctx_empty` = 1, `ctx_full` = 0.
  - Stack contents are don't-care.
- Each register holds its value unless its strobe is high at a rising `clk`.
- Push (`ctx_push` & !`ctx_pop` & !`ctx_full`):
  - writes {bank, psr, acc[bank]} into entry `ctx_count`, then increments `ctx_count`.
  - Saved values are the pre-edge values, even when `acc_update`, `psr_update` or `bank_update` is also high that cycle; those updates still take effect.
- Pop (`ctx_pop` & !`ctx_push` & !`ctx_empty`):
  - decrements `ctx_count` and restores `bank`, `psr` and `acc[saved bank]` from entry `ctx_count-1`.
  - A restore overrides `acc_update`, `psr_update` and `bank_update` on the same edge.
  - Accumulators other than the saved one are unchanged.
- Error cases:
  - push when full: stack unchanged, `ctx_err` set.
  - pop when empty: stack unchanged, `ctx_err` set.
  - push and pop in the same cycle: stack unchanged, `ctx_err` set.
- `ctx_err` clears only on reset or `ctx_err_clr`. If a set condition and `ctx_err_clr` occur on the same edge, set wins.
- `acc_update` together with `bank_update` on the same edge writes the accumulator selected by the old `bank`.
- `opcode_update` and `imm_update` may be asserted together; both load `imem_data`.
- `opa`, `dmem_data_w` and `dmem_addr_reg` track `bank` combinationally.

## Timing
- All state updates on the rising `clk` edge.
- All outputs are combinational from registers only; there is no input-to-output combinational path.
- Write-to-read latency is 1 cycle: a value written at edge N is visible on the outputs after edge N.
- Push/pop latency is 1 cycle. `ctx_count`, `ctx_full` and `ctx_empty` are valid after the same edge.
- Reset asserted mid-operation immediately forces all reset values, including an empty stack.

## Configuration
- `REGS_CTX_STACK_EN` defined: the context stack is built as described above.
- `REGS_CTX_STACK_EN` undefined:
  - no stack storage; `ctx_push`, `ctx_pop` and `ctx_err_clr` are ignored.
  - `ctx_count` = 0, `ctx_empty` = 1, `ctx_full` = 0, `ctx_err` = 0, all constant.
  - All other behaviour is identical.

## Test plan
- **Reset and basic loads.**
  - Stimulus: reset, then `opcode_update` with `imem_data`=0x3C, then `imm_update` with 0x5A.
  - Required: `opcode`=OPCODE_RST during reset, 0x3C after the first edge; `opb`=0x5A.
- **Bank isolation.**
  - Stimulus: `bank_sel`=2 with `bank_update`; `alu`=0xA5 with `acc_update`; `bank_sel`=0 with `bank_update`.
  - Required: `opa`=0x00 on bank 0. Reselecting bank 2 gives `opa`=`dmem_addr_reg`=0xA5.
- **Push/pop round trip.**
  - Stimulus: bank=1, acc[1]=0x11, psr=0x5; `ctx_push`; then bank=3, acc[1]=0x77, psr=0xA; `ctx_pop`.
  - Required: after the pop, bank=1, `opa`=0x11, psr=0x5, `ctx_empty`=1.
- **Overflow.**
  - Stimulus: 4 pushes, then a fifth push (CTX_DEPTH=4).
  - Required: `ctx_full`=1, `ctx_count`=4, `ctx_err`=1 after the fifth push. A following pop restores the 4th pushed context.
- **Underflow and conflict.**
  - Stimulus: pop on empty; then `ctx_err_clr`; then push and pop in the same cycle.
  - Required: `ctx_err` set by the pop, cleared by `ctx_err_clr`, set again by push+pop; `ctx_count` stays 0 throughout.
- **Same-edge events.**
  - Stimulus: `ctx_push` with `acc_update` (`alu`=0x99, acc=0x10).
  - Required: acc=0x99 after the edge; a later pop restores 0x10. A `ctx_pop` with `acc_update` on the same edge gives the restored value.
